// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared types and sizing for the nibble-serial 16-bit ALU.
//
// Contents:
//   WIDTH    operand/result width in bits
//   NIBBLES  number of 4-bit slices processed per command
//   IDX_W    width of the nibble index counter
//   op_e     operation codes carried on cmd_op
//   state_e  sequencer states
package alu_seq_pkg;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble.sv
// alu_nibble -- purely combinational 4-bit ALU slice.
//
// Ports:
//   a, b   4-bit operand slices
//   op     operation (op_e)
//   cin    carry-in for ADD/SUB, serial-in bit for SHL/SHR, ignored otherwise
//   y      4-bit result slice
//   cout   carry-out for ADD/SUB, shifted-out bit for SHL/SHR, 0 otherwise
module alu_nibble
  import alu_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  op_e        op,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] w_sum;

  // Slice datapath. SUB is built as a + ~b + cin, so the caller supplies
  // cin = 1 on the lowest slice to complete the two's complement.
  always_comb begin
    w_sum = 5'd0;
    y     = 4'd0;
    cout  = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        y     = w_sum[3:0];
        cout  = w_sum[4];
      end
      OP_SUB: begin
        w_sum = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        y     = w_sum[3:0];
        cout  = w_sum[4];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y    = {a[2:0], cin};
        cout = a[3];
      end
      OP_SHR: begin
        y    = {cin, a[3:1]};
        cout = a[0];
      end
      default: begin
        y    = 4'd0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq16.sv
// alu_seq16 -- 16-bit ALU that evaluates one nibble per clock, LSB first.
//
// A command is accepted in IDLE, four RUN cycles build the result one
// nibble at a time through a single alu_nibble slice, and the result is
// presented in DONE until the response handshake completes.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command valid          cmd_ready  high only in IDLE
//   cmd_a/b    16-bit operands        cmd_op     3-bit operation (op_e)
//   rsp_valid  high only in DONE      rsp_ready  response accept
//   rsp_y      16-bit result
//   rsp_cout   ADD/SUB carry-out, SHL/SHR shifted-out bit, 0 for logic ops
//   rsp_zero   result equals zero
//   rsp_ovf    signed overflow for ADD/SUB (present only with ALU_SEQ_OVF_EN)
//
// Build option: define ALU_SEQ_OVF_EN to add the rsp_ovf port and logic.
module alu_seq16
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic        rsp_cout,
`ifdef ALU_SEQ_OVF_EN
  output logic        rsp_ovf,
`endif
  output logic        rsp_zero
);

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_y;
  op_e                r_op;
  logic               r_carry;
  logic               r_cmdReady;
  logic               r_rspValid;
  logic               r_cout;
  logic               r_zero;

  logic [3:0]         w_bitBase;
  logic [3:0]         w_nibA;
  logic [3:0]         w_nibB;
  logic [3:0]         w_nibY;
  logic               w_nibCin;
  logic               w_nibCout;
  logic [WIDTH-1:0]   w_aShl;
  logic [WIDTH-1:0]   w_aShr;
  logic               w_lastNib;
  logic               w_finalCout;
  logic               w_zero;

`ifdef ALU_SEQ_OVF_EN
  logic               r_ovf;
  logic               w_bEffMsb;
  logic               w_ovf;
`endif

  assign w_bitBase = {r_idx, 2'b00};
  assign w_nibA    = r_a[w_bitBase +: 4];
  assign w_nibB    = r_b[w_bitBase +: 4];
  assign w_lastNib = (r_idx == IDX_W'(NIBBLES - 1));

  // Operand pre-shifted by one place so the serial-in bit of any slice is a
  // plain indexed pick: bit 4i of the left-shifted copy is A[4i-1], bit 4i+3
  // of the right-shifted copy is A[4i+4], and the zero fill at either end
  // supplies the 0 beyond bit 0 / bit 15.
  assign w_aShl = {r_a[WIDTH-2:0], 1'b0};
  assign w_aShr = {1'b0, r_a[WIDTH-1:1]};

  // Slice carry-in: the running carry for arithmetic, the neighbouring
  // operand bit for shifts.
  always_comb begin
    w_nibCin = r_carry;
    case (r_op)
      OP_SHL:  w_nibCin = w_aShl[w_bitBase];
      OP_SHR:  w_nibCin = w_aShr[w_bitBase + 4'd3];
      default: w_nibCin = r_carry;
    endcase
  end

  alu_nibble u_nibble (
    .a    (w_nibA),
    .b    (w_nibB),
    .op   (r_op),
    .cin  (w_nibCin),
    .y    (w_nibY),
    .cout (w_nibCout)
  );

  // Flags captured while the top nibble is being written. The zero test
  // looks at the incoming top nibble together with the three already stored.
  assign w_zero = ({w_nibY, r_y[WIDTH-5:0]} == '0);

  always_comb begin
    w_finalCout = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: w_finalCout = w_nibCout;
      OP_SHL:         w_finalCout = r_a[WIDTH-1];
      OP_SHR:         w_finalCout = r_a[0];
      default:        w_finalCout = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  // Signed overflow: both addends share a sign and the result sign differs.
  // For SUB the second addend is ~B, so its sign bit is inverted.
  assign w_bEffMsb = (r_op == OP_SUB) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
  assign w_ovf     = ((r_op == OP_ADD) || (r_op == OP_SUB)) &&
                     (r_a[WIDTH-1] == w_bEffMsb) &&
                     (w_nibY[3] != r_a[WIDTH-1]);
`endif

  // Sequencer. All handshake and result outputs are registers so they stay
  // frozen in DONE for as long as the consumer stalls. Operands are latched
  // only on acceptance, so cmd_* activity outside IDLE has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
      r_y        <= '0;
      r_carry    <= 1'b0;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_a        <= cmd_a;
            r_b        <= cmd_b;
            r_op       <= op_e'(cmd_op);
            r_idx      <= '0;
            r_y        <= '0;
            r_carry    <= (op_e'(cmd_op) == OP_SUB);
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= 1'b0;
`endif
            r_cmdReady <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_y[w_bitBase +: 4] <= w_nibY;
          r_carry             <= w_nibCout;
          r_idx               <= r_idx + IDX_W'(1);
          if (w_lastNib) begin
            r_cout     <= w_finalCout;
            r_zero     <= w_zero;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= w_ovf;
`endif
            r_rspValid <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_rspValid <= 1'b0;
          r_cmdReady <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmdReady;
  assign rsp_valid = r_rspValid;
  assign rsp_y     = r_y;
  assign rsp_cout  = r_cout;
  assign rsp_zero  = r_zero;
`ifdef ALU_SEQ_OVF_EN
  assign rsp_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16 -- directed and random scoreboard bench for alu_seq16.
// Expected results are queued as each command is driven and popped when the
// response appears. Define ALU_SEQ_OVF_EN to also cover rsp_ovf.
module tb_alu_seq16;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_y;
  logic        rsp_cout;
  logic        rsp_zero;
`ifdef ALU_SEQ_OVF_EN
  logic        rsp_ovf;
`endif

  int   total     = 0;
  int   bad       = 0;
  int   hsCount   = 0;
  int   doneCount = 0;
  exp_t sbQ[$];

  // 10-unit clock period.
  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_cout  (rsp_cout),
`ifdef ALU_SEQ_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_zero  (rsp_zero)
  );

  // Counts every completed response handshake so spurious responses show up.
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) hsCount <= hsCount + 1;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Whole-word reference model.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        r;
    logic [16:0] s;
    r = '0;
    s = '0;
    case (op)
      3'd0: begin
        s      = {1'b0, a} + {1'b0, b};
        r.y    = s[15:0];
        r.cout = s[16];
        r.ovf  = (a[15] == b[15]) && (r.y[15] != a[15]);
      end
      3'd1: begin
        s      = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r.y    = s[15:0];
        r.cout = s[16];
        r.ovf  = (a[15] != b[15]) && (r.y[15] != a[15]);
      end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~a;
      3'd6: begin
        r.y    = {a[14:0], 1'b0};
        r.cout = a[15];
      end
      default: begin
        r.y    = {1'b0, a[15:1]};
        r.cout = a[0];
      end
    endcase
    r.zero = (r.y == 16'h0000);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command, queues its expected result and steps through the
  // accepting edge. Operands are scrambled afterwards to show they are
  // ignored; cmd_valid stays high when holdValid is set.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input exp_t e, input bit holdValid);
    int n;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    sbQ.push_back(e);
    doneCount++;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    checkOutput("accept_ready", cmd_ready, 1);
    step();
    checkOutput("ready_after_accept", cmd_ready, 0);
    if (!holdValid) cmd_valid = 1'b0;
    cmd_a  = ~cmd_a;
    cmd_b  = cmd_b ^ 16'h5A5A;
    cmd_op = cmd_op + 3'd3;
  endtask

  // Waits for rsp_valid (bounded), checks latency and result against the
  // scoreboard head, and completes the handshake if rsp_ready is high.
  task automatic checkResponse(input string tag, output exp_t e);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, 4);
    if (sbQ.size() > 0) e = sbQ.pop_front();
    else                e = 'x;
    checkOutput({tag, "_y"},    rsp_y,    e.y);
    checkOutput({tag, "_cout"}, rsp_cout, e.cout);
    checkOutput({tag, "_zero"}, rsp_zero, e.zero);
`ifdef ALU_SEQ_OVF_EN
    checkOutput({tag, "_ovf"},  rsp_ovf,  e.ovf);
`endif
    if (rsp_ready) begin
      step();
      checkOutput({tag, "_valid_drop"}, rsp_valid, 0);
    end
  endtask

  task automatic runDirected(input string tag, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] y, input logic cout,
                             input logic zero, input logic ovf);
    exp_t e;
    exp_t got;
    e.y    = y;
    e.cout = cout;
    e.zero = zero;
    e.ovf  = ovf;
    applyStimulus(op, a, b, e, 1'b0);
    checkResponse(tag, got);
  endtask

  initial begin
    exp_t       e;
    exp_t       got;
    int         hsBefore;
    logic       sawValid;
    logic [2:0] rop;
    logic [15:0] ra;
    logic [15:0] rb;

    // Reset with a command offered: reset must win, nothing accepted.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 16'h1234;
    cmd_b     = 16'h0001;
    cmd_op    = 3'd0;
    rsp_ready = 1'b1;
    step();
    step();
    checkOutput("rst_ready", cmd_ready, 1);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("rst_valid", rsp_valid, 0);
    checkOutput("rst_y",     rsp_y,     16'h0000);
    checkOutput("rst_cout",  rsp_cout,  0);
    checkOutput("rst_zero",  rsp_zero,  0);
`ifdef ALU_SEQ_OVF_EN
    checkOutput("rst_ovf",   rsp_ovf,   0);
`endif

    // Directed vectors with hand-derived results.
    runDirected("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    runDirected("sub_neg",   3'd1, 16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    runDirected("sub_ovf",   3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    runDirected("shl_msb",   3'd6, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0);
    runDirected("shr_lsb",   3'd7, 16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0);
    runDirected("not_ones",  3'd5, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    runDirected("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
    runDirected("and",       3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0);
    runDirected("or",        3'd3, 16'h0F0F, 16'h00F0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    runDirected("xor_zero",  3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0);
    runDirected("sub_eq",    3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
    runDirected("add_plain", 3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    runDirected("shl_cross", 3'd6, 16'h0888, 16'h0000, 16'h1110, 1'b0, 1'b0, 1'b0);
    runDirected("shr_cross", 3'd7, 16'h1110, 16'h0000, 16'h0888, 1'b0, 1'b0, 1'b0);

    // Backpressure: response held 10 clocks with a new command pending.
    rsp_ready = 1'b0;
    e.y = 16'h3333; e.cout = 1'b0; e.zero = 1'b0; e.ovf = 1'b0;
    applyStimulus(3'd0, 16'h1111, 16'h2222, e, 1'b1);
    checkResponse("bp", got);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_y",     rsp_y,     got.y);
      checkOutput("bp_cout",  rsp_cout,  got.cout);
      checkOutput("bp_zero",  rsp_zero,  got.zero);
`ifdef ALU_SEQ_OVF_EN
      checkOutput("bp_ovf",   rsp_ovf,   got.ovf);
`endif
      checkOutput("bp_valid", rsp_valid, 1);
      checkOutput("bp_ready", cmd_ready, 0);
    end
    cmd_op = 3'd4;
    cmd_a  = 16'hA5A5;
    cmd_b  = 16'hFFFF;
    e.y = 16'h5A5A; e.cout = 1'b0; e.zero = 1'b0; e.ovf = 1'b0;
    sbQ.push_back(e);
    doneCount++;
    rsp_ready = 1'b1;
    step();
    checkOutput("bp_rel_valid", rsp_valid, 0);
    checkOutput("bp_rel_ready", cmd_ready, 1);
    step();
    checkOutput("bp2_accept", cmd_ready, 0);
    cmd_valid = 1'b0;
    checkResponse("bp2", got);

    // Reset two clocks after acceptance aborts the command silently.
    hsBefore  = hsCount;
    cmd_op    = 3'd0;
    cmd_a     = 16'h00FF;
    cmd_b     = 16'h0001;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_valid", rsp_valid, 0);
    checkOutput("abort_y",     rsp_y,     16'h0000);
    checkOutput("abort_cout",  rsp_cout,  0);
    checkOutput("abort_zero",  rsp_zero,  0);
`ifdef ALU_SEQ_OVF_EN
    checkOutput("abort_ovf",   rsp_ovf,   0);
`endif
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      sawValid = sawValid | rsp_valid;
    end
    checkOutput("abort_novalid", sawValid, 0);
    checkOutput("abort_hs",      hsCount,  hsBefore);

    // Random commands checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      applyStimulus(rop, ra, rb, model(rop, ra, rb), 1'b0);
      checkResponse("rand", got);
    end

    checkOutput("hs_count", hsCount, doneCount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: cmd_valid in 1, cmd_ready out 1, command handshake; transfer when both high on a clk edge.
REQ-004 SHALL have ports: cmd_a in 16, cmd_b in 16, operands; cmd_op in 3, operation select.
REQ-005 SHALL have ports: rsp_valid out 1, rsp_ready in 1, response handshake.
REQ-006 SHALL have ports: rsp_y out 16 result; rsp_cout out 1 carry/shifted-out bit; rsp_zero out 1 result-zero flag.
REQ-007 SHALL have port rsp_ovf out 1 signed-overflow flag, only when ALU_SEQ_OVF_EN is defined.

Function
REQ-008 SHALL encode cmd_op: 0 ADD, 1 SUB (A+~B+1), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1, 7 SHR1.
REQ-009 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-010 SHALL assert cmd_ready only in IDLE; in IDLE, command transfer latches cmd_a/cmd_b/cmd_op and enters RUN with nibble index 0.
REQ-011 SHALL, in RUN, compute one 4-bit nibble per clock, LSB nibble first, index 0..3, writing it into rsp_y[4i+3:4i]; after index 3 enter DONE.
REQ-012 SHALL chain carry between nibbles for ADD/SUB: carry-in of nibble 0 is 0 for ADD, 1 for SUB; carry-out of nibble i feeds nibble i+1.
REQ-013 SHALL, for SHL1/SHR1, take the serial-in bit from the latched neighbouring operand bit (A[4i-1] for SHL, A[4i+4] for SHR), 0 beyond bit 0/bit 15.
REQ-014 SHALL set rsp_cout: ADD/SUB carry-out of nibble 3 (SUB: 1 means A>=B unsigned); SHL1 A[15]; SHR1 A[0]; logic ops 0.
REQ-015 SHALL set rsp_zero = (rsp_y == 0) for every op, valid in DONE.
REQ-016 SHALL assert rsp_valid only in DONE; rsp_valid rises exactly 4 clocks after the accepting edge.
REQ-017 SHALL hold rsp_y/rsp_cout/rsp_zero/rsp_ovf stable while rsp_valid=1 and rsp_ready=0, indefinitely.
REQ-018 SHALL return to IDLE on the edge where rsp_valid and rsp_ready are both high; no command accepted in that same cycle (minimum 6 clocks per command).
REQ-019 SHALL ignore cmd_valid and cmd_* changes outside IDLE; latched operands unaffected.

Reset
REQ-020 SHALL, with rst high on an edge, force IDLE, nibble index 0, rsp_valid 0, rsp_y 0, rsp_cout 0, rsp_zero 0, rsp_ovf 0; cmd_ready 1 the cycle after.
REQ-021 SHALL abort any in-flight command on reset; no response for it is ever produced.
REQ-022 SHALL give reset priority over any simultaneous handshake.

Configuration
REQ-023 SHALL, with ALU_SEQ_OVF_EN defined, drive rsp_ovf = signed overflow of ADD/SUB (carry into bit 15 XOR carry out of bit 15), 0 for other ops.
REQ-024 SHALL, without ALU_SEQ_OVF_EN, omit rsp_ovf port and its logic; all other behaviour identical.

Structure
REQ-025 SHALL place in package alu_seq_pkg: op-code enum, FSM state enum, WIDTH=16, NIBBLES=4.
REQ-026 SHALL use one sub-module alu_nibble: combinational 4-bit slice with inputs a, b, op, cin/serial-in, outputs y, cout.

Verification
REQ-027 ADD 0xFFFF+0x0001 -> rsp_y 0x0000, cout 1, zero 1, rsp_valid 4 clocks after accept.
REQ-028 SUB 0x1234-0x1235 -> rsp_y 0xFFFF, cout 0, zero 0, ovf 0; SUB 0x8000-0x0001 -> 0x7FFF, cout 1, ovf 1.
REQ-029 SHL1 0x8001 -> 0x0002, cout 1; SHR1 0x8001 -> 0x4000, cout 1; NOT 0xFFFF -> 0x0000, zero 1.
REQ-030 rsp_ready low 10 clocks in DONE with cmd_valid high -> outputs stable, cmd_ready 0, second command accepted only after response handshake.
REQ-031 rst pulsed 2 clocks after accept -> next cycle cmd_ready 1, rsp_valid 0, all outputs 0, no response observed.
REQ-032 ADD 0x7FFF+0x0001 -> 0x8000, cout 0, ovf 1 (macro defined); port absent, compile clean (macro undefined).
